// File: rtl/snoop_pkg.sv
// Shared definitions for the snooping bus: opcodes, snoop results and the
// bus-master state encoding used by the initiator, responder and controller.
package snoop_pkg;

  localparam logic [7:0] OP_NOP        = 8'd0;
  localparam logic [7:0] OP_READ       = 8'd1;
  localparam logic [7:0] OP_WRITE      = 8'd2;
  localparam logic [7:0] OP_INVALIDATE = 8'd3;
  localparam logic [7:0] OP_RWIM       = 8'd4;

  localparam logic [1:0] RES_NOHIT   = 2'b00;
  localparam logic [1:0] RES_HIT     = 2'b01;
  localparam logic [1:0] RES_HITM    = 2'b10;
  localparam logic [1:0] RES_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_SNOOP   = 3'd2,
    ST_BACKOFF = 3'd3,
    ST_DATA    = 3'd4,
    ST_RESP    = 3'd5
  } master_state_e;

  function automatic logic op_is_legal(input logic [7:0] op);
    return (op >= OP_READ) && (op <= OP_RWIM);
  endfunction

  // Only read-type operations may be retried after a HITM.
  function automatic logic op_is_read_type(input logic [7:0] op);
    return (op == OP_READ) || (op == OP_RWIM);
  endfunction

endpackage

// File: rtl/snoop_wait_counter.sv
// Loadable down-counter; done_o is high while the count is zero.
module snoop_wait_counter #(
  parameter int Width = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q;

  // Load has priority; otherwise count down and saturate at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - {{(Width-1){1'b0}}, 1'b1};
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/snoop_bus_master.sv
// Requesting end of the shared snooping bus: issues one operation at a time,
// samples the snoop result, retries read-type ops once after HITM.
module snoop_bus_master
  import snoop_pkg::*;
#(
  parameter int lineSize      = 512,
  parameter int addrWidth     = 32,
  parameter int snoopWait     = 1,
  parameter int backoffCycles = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [7:0]           req_op,
  input  logic [addrWidth-1:0] req_addr,
  input  logic [lineSize-1:0]  req_data,
  output logic [lineSize-1:0]  sharedBusOut,
  output logic [7:0]           sharedOperationBusOut,
  input  logic [1:0]           snoopBusIn,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_result,
  output logic                 rsp_retried,
  output logic                 rsp_err
);

  localparam int CntMax = (snoopWait > backoffCycles) ? snoopWait : backoffCycles;
  localparam int CntW   = (CntMax < 2) ? 1 : $clog2(CntMax);

  master_state_e        state_q, state_d;
  logic [7:0]           op_q, op_d;
  logic [addrWidth-1:0] addr_q, addr_d;
  logic [lineSize-1:0]  data_q, data_d;
  logic                 retried_q, retried_d;
  logic [1:0]           result_q, result_d;
  logic                 err_q, err_d;
  logic                 cnt_load_s;
  logic [CntW-1:0]      cnt_val_s;
  logic                 cnt_done_s;

  snoop_wait_counter #(.Width(CntW)) u_wait (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cnt_load_s),
    .load_val_i(cnt_val_s),
    .done_o    (cnt_done_s)
  );

  // State and captured-operation registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NOP;
      addr_q    <= '0;
      data_q    <= '0;
      retried_q <= 1'b0;
      result_q  <= RES_NOHIT;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      retried_q <= retried_d;
      result_q  <= result_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic, request capture and snoop sampling.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    retried_d  = retried_q;
    result_d   = result_q;
    err_d      = err_q;
    cnt_load_s = 1'b0;
    cnt_val_s  = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d      = req_op;
          addr_d    = req_addr;
          data_d    = req_data;
          retried_d = 1'b0;
          result_d  = RES_NOHIT;
          if (op_is_legal(req_op)) begin
            err_d   = 1'b0;
            state_d = ST_ADDR;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        cnt_load_s = 1'b1;
        cnt_val_s  = CntW'(snoopWait - 1);
        state_d    = ST_SNOOP;
      end
      ST_SNOOP: begin
        if (cnt_done_s) begin
          // Code 11 behaves as NOHIT for flow control but is flagged.
          err_d    = (snoopBusIn == RES_ILLEGAL);
          result_d = (snoopBusIn == RES_ILLEGAL) ? RES_NOHIT : snoopBusIn;
          if ((snoopBusIn == RES_HITM) && op_is_read_type(op_q) && !retried_q) begin
            retried_d  = 1'b1;
            cnt_load_s = 1'b1;
            cnt_val_s  = CntW'(backoffCycles - 1);
            state_d    = ST_BACKOFF;
          end else if (op_q == OP_WRITE) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_SNOOP;
        end
      end
      ST_BACKOFF: begin
        if (cnt_done_s) begin
          state_d = ST_ADDR;
        end else begin
          state_d = ST_BACKOFF;
        end
      end
      ST_DATA: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded purely from registered state.
  always_comb begin
    sharedBusOut          = '0;
    sharedOperationBusOut = OP_NOP;
    req_ready             = 1'b0;
    rsp_valid             = 1'b0;
    rsp_result            = RES_NOHIT;
    rsp_retried           = 1'b0;
    rsp_err               = 1'b0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_ADDR, ST_SNOOP: begin
        sharedBusOut[addrWidth-1:0] = addr_q;
        sharedOperationBusOut       = op_q;
      end
      ST_DATA: begin
        sharedBusOut          = data_q;
        sharedOperationBusOut = op_q;
      end
      ST_RESP: begin
        rsp_valid   = 1'b1;
        rsp_result  = result_q;
        rsp_retried = retried_q;
        rsp_err     = err_q;
      end
      default: begin
        sharedBusOut          = '0;
        sharedOperationBusOut = OP_NOP;
      end
    endcase
  end

endmodule

// File: tb/tb_snoop_bus_master.sv
// Directed bench for snoop_bus_master with a nibble-decoding snoop responder.
module tb_snoop_bus_master;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [7:0]   req_op = 8'd0;
  logic [31:0]  req_addr = 32'd0;
  logic [511:0] req_data = '0;
  logic [511:0] sharedBusOut;
  logic [7:0]   sharedOperationBusOut;
  logic [1:0]   snoopBusIn;
  logic         rsp_valid;
  logic [1:0]   rsp_result;
  logic         rsp_retried;
  logic         rsp_err;
  logic         force11 = 1'b0;
  logic [511:0] a5_line;
  int           errors = 0;
  int           checks = 0;
  int           stray;

  always #5 clk = ~clk;

  snoop_bus_master dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_op               (req_op),
    .req_addr             (req_addr),
    .req_data             (req_data),
    .sharedBusOut         (sharedBusOut),
    .sharedOperationBusOut(sharedOperationBusOut),
    .snoopBusIn           (snoopBusIn),
    .rsp_valid            (rsp_valid),
    .rsp_result           (rsp_result),
    .rsp_retried          (rsp_retried),
    .rsp_err              (rsp_err)
  );

  always_comb begin
    if (force11) begin
      snoopBusIn = 2'b11;
    end else begin
      case (sharedBusOut[3:0])
        4'h2, 4'h8: snoopBusIn = 2'b01;
        4'h4, 4'hC: snoopBusIn = 2'b10;
        default:    snoopBusIn = 2'b00;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshake happens at the posedge ending this task (edge 0).
  task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [511:0] data);
    @(negedge clk);
    chk("ready_before_issue", 512'(req_ready), 512'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) a5_line[i*8 +: 8] = 8'hA5;

    // Reset state
    #2;
    chk("rst_ready", 512'(req_ready), 512'd1);
    chk("rst_rsp_valid", 512'(rsp_valid), 512'd0);
    chk("rst_bus", sharedBusOut, 512'd0);
    chk("rst_op", 512'(sharedOperationBusOut), 512'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // READ 0x1000 -> NOHIT in cycle 3
    issue(8'd1, 32'h1000, '0);
    @(negedge clk);
    chk("rd0_c1_bus", sharedBusOut, 512'h1000);
    chk("rd0_c1_op", 512'(sharedOperationBusOut), 512'd1);
    chk("rd0_c1_ready", 512'(req_ready), 512'd0);
    @(negedge clk);
    chk("rd0_c2_bus", sharedBusOut, 512'h1000);
    chk("rd0_c2_valid", 512'(rsp_valid), 512'd0);
    @(negedge clk);
    chk("rd0_c3_valid", 512'(rsp_valid), 512'd1);
    chk("rd0_c3_result", 512'(rsp_result), 512'd0);
    chk("rd0_c3_retried", 512'(rsp_retried), 512'd0);
    chk("rd0_c3_err", 512'(rsp_err), 512'd0);
    chk("rd0_c3_bus", sharedBusOut, 512'd0);
    chk("rd0_c3_op", 512'(sharedOperationBusOut), 512'd0);
    @(negedge clk);
    chk("rd0_c4_valid", 512'(rsp_valid), 512'd0);
    chk("rd0_c4_ready", 512'(req_ready), 512'd1);

    // READ 0x1002 -> HIT
    issue(8'd1, 32'h1002, '0);
    repeat (3) @(negedge clk);
    chk("rd2_valid", 512'(rsp_valid), 512'd1);
    chk("rd2_result", 512'(rsp_result), 512'd1);
    chk("rd2_retried", 512'(rsp_retried), 512'd0);

    // INVALIDATE 0x2008 -> HIT, op 3 on bus
    issue(8'd3, 32'h2008, '0);
    @(negedge clk);
    chk("inv_c1_op", 512'(sharedOperationBusOut), 512'd3);
    chk("inv_c1_bus", sharedBusOut, 512'h2008);
    repeat (2) @(negedge clk);
    chk("inv_valid", 512'(rsp_valid), 512'd1);
    chk("inv_result", 512'(rsp_result), 512'd1);

    // RWIM 0x300C -> HITM, backoff, retry, HITM again
    issue(8'd4, 32'h300C, '0);
    @(negedge clk);
    chk("rwim_c1_op", 512'(sharedOperationBusOut), 512'd4);
    @(negedge clk);
    chk("rwim_c2_bus", sharedBusOut, 512'h300C);
    @(negedge clk);
    chk("rwim_c3_bus", sharedBusOut, 512'd0);
    chk("rwim_c3_op", 512'(sharedOperationBusOut), 512'd0);
    chk("rwim_c3_valid", 512'(rsp_valid), 512'd0);
    repeat (3) @(negedge clk);
    chk("rwim_c6_op", 512'(sharedOperationBusOut), 512'd0);
    @(negedge clk);
    chk("rwim_c7_bus", sharedBusOut, 512'h300C);
    chk("rwim_c7_op", 512'(sharedOperationBusOut), 512'd4);
    @(negedge clk);
    chk("rwim_c8_valid", 512'(rsp_valid), 512'd0);
    @(negedge clk);
    chk("rwim_c9_valid", 512'(rsp_valid), 512'd1);
    chk("rwim_c9_result", 512'(rsp_result), 512'd2);
    chk("rwim_c9_retried", 512'(rsp_retried), 512'd1);
    chk("rwim_c9_err", 512'(rsp_err), 512'd0);

    // WRITE 0x4004 -> HITM, no retry, DATA in cycle 3
    issue(8'd2, 32'h4004, a5_line);
    repeat (3) @(negedge clk);
    chk("wr_c3_bus", sharedBusOut, a5_line);
    chk("wr_c3_op", 512'(sharedOperationBusOut), 512'd2);
    chk("wr_c3_valid", 512'(rsp_valid), 512'd0);
    @(negedge clk);
    chk("wr_c4_valid", 512'(rsp_valid), 512'd1);
    chk("wr_c4_result", 512'(rsp_result), 512'd2);
    chk("wr_c4_retried", 512'(rsp_retried), 512'd0);

    // Illegal opcode 7 -> immediate error response
    issue(8'd7, 32'h1000, '0);
    @(negedge clk);
    chk("ill_valid", 512'(rsp_valid), 512'd1);
    chk("ill_err", 512'(rsp_err), 512'd1);
    chk("ill_result", 512'(rsp_result), 512'd0);
    chk("ill_bus", sharedBusOut, 512'd0);
    chk("ill_op", 512'(sharedOperationBusOut), 512'd0);

    // Forced snoop code 11
    force11 = 1'b1;
    issue(8'd1, 32'h1000, '0);
    repeat (3) @(negedge clk);
    chk("s11_valid", 512'(rsp_valid), 512'd1);
    chk("s11_result", 512'(rsp_result), 512'd0);
    chk("s11_err", 512'(rsp_err), 512'd1);
    force11 = 1'b0;

    // Reset during BACKOFF
    issue(8'd4, 32'h300C, '0);
    repeat (4) @(negedge clk);
    chk("bo_inflight_op", 512'(sharedOperationBusOut), 512'd0);
    rst_n = 1'b0;
    #1;
    chk("bo_rst_ready", 512'(req_ready), 512'd1);
    chk("bo_rst_valid", 512'(rsp_valid), 512'd0);
    chk("bo_rst_bus", sharedBusOut, 512'd0);
    chk("bo_rst_op", 512'(sharedOperationBusOut), 512'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) stray++;
    end
    chk("bo_no_stray_rsp", 512'(stray), 512'd0);
    chk("bo_ready_after", 512'(req_ready), 512'd1);

    issue(8'd1, 32'h1000, '0);
    @(negedge clk);
    chk("post_c1_bus", sharedBusOut, 512'h1000);
    repeat (2) @(negedge clk);
    chk("post_valid", 512'(rsp_valid), 512'd1);
    chk("post_result", 512'(rsp_result), 512'd0);
    chk("post_retried", 512'(rsp_retried), 512'd0);
    chk("post_err", 512'(rsp_err), 512'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
